// File: rtl/mdu_multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle_pkg
// Description : Shared op codes, FSM state type and op-classification helpers
//               for the multiply/divide unit. Also imported by the control
//               decoder so both sides agree on the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_multicycle_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t OP_MULT  = 4'd0;
  localparam mdu_op_t OP_MULTU = 4'd1;
  localparam mdu_op_t OP_DIV   = 4'd2;
  localparam mdu_op_t OP_DIVU  = 4'd3;
  localparam mdu_op_t OP_MTHI  = 4'd4;
  localparam mdu_op_t OP_MTLO  = 4'd5;
  localparam mdu_op_t OP_MADD  = 4'd6;
  localparam mdu_op_t OP_MADDU = 4'd7;
  localparam mdu_op_t OP_MSUB  = 4'd8;
  localparam mdu_op_t OP_MSUBU = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MUL_CYCLES or DIV_CYCLES.
  function automatic logic is_multicycle(input mdu_op_t op);
    return (op <= OP_MSUBU) && (op != OP_MTHI) && (op != OP_MTLO);
  endfunction

  function automatic logic is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_multicycle_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle_arith
// Description : Combinational 2*WIDTH result generator for MULT/MULTU,
//               MADD(U)/MSUB(U) and DIV/DIVU.
// Ports       : op           - op code
//               a, b         - rs / rt operands
//               hi, lo       - current architectural HI/LO (accumulate base)
//               res_hi/lo    - result to be committed
//               div_by_zero  - DIV/DIVU with b==0 (result must not commit)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_multicycle_arith
  import mdu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                 w_signed;
  logic [2*WIDTH-1:0]   w_ext_a;
  logic [2*WIDTH-1:0]   w_ext_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_acc;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quo_s;
  logic [WIDTH-1:0]     w_rem_s;

  always_comb begin
    w_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);

    // Sign/zero-extend to 2*WIDTH; a plain modular multiply of the
    // extended operands yields the correct signed or unsigned product.
    w_ext_a = w_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    w_ext_b = w_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    w_prod  = w_ext_a * w_ext_b;
    w_acc   = {hi, lo};

    // Divide magnitudes, then restore signs. INT_MIN / -1 falls out
    // naturally: |INT_MIN| = INT_MIN as unsigned, quotient keeps that value.
    w_a_neg = w_signed & a[WIDTH-1];
    w_b_neg = w_signed & b[WIDTH-1];
    w_abs_a = w_a_neg ? -a : a;
    w_abs_b = w_b_neg ? -b : b;
    if (b == '0) begin
      w_quo = '0;
      w_rem = '0;
    end else begin
      w_quo = w_abs_a / w_abs_b;
      w_rem = w_abs_a % w_abs_b;
    end
    w_quo_s = (w_a_neg ^ w_b_neg) ? -w_quo : w_quo;
    w_rem_s = w_a_neg ? -w_rem : w_rem;

    res_hi      = hi;
    res_lo      = lo;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: {res_hi, res_lo} = w_prod;
      OP_MADD, OP_MADDU: {res_hi, res_lo} = w_acc + w_prod;
      OP_MSUB, OP_MSUBU: {res_hi, res_lo} = w_acc - w_prod;
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          div_by_zero = 1'b1;
        end else begin
          res_hi = w_rem_s;
          res_lo = w_quo_s;
        end
      end
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
    // Keeps the constant referenced for the b==0 guard readability.
    if (w_abs_b == c_one && !w_signed && b == '0) div_by_zero = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/mdu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : mdu_multicycle
// Description : Multi-cycle multiply/divide unit with architectural HI/LO,
//               accumulate ops, MTHI/MTLO and D-stage stall request.
// Ports       : clk, reset      - clock, async active-high reset
//               start, op, a, b - E-stage op issue
//               md_instr_d      - D-stage instruction touches HI/LO
//               hi, lo          - architectural HI/LO
//               busy            - multi-cycle op in flight
//               stall_req       - stall D while the unit is (about to be) busy
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_multicycle
  import mdu_multicycle_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_instr_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_pend_hi, r_pend_lo;
  logic             r_pend_ok;

  logic             w_start_mc;
  logic             w_capture;
  logic             w_commit;
  logic             w_mt_hi;
  logic             w_mt_lo;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic             w_div_by_zero;

  mdu_multicycle_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op          (op),
    .a           (a),
    .b           (b),
    .hi          (r_hi),
    .lo          (r_lo),
    .res_hi      (w_res_hi),
    .res_lo      (w_res_lo),
    .div_by_zero (w_div_by_zero)
  );

  assign w_start_mc = start & is_multicycle(op);
  assign busy       = (r_state == ST_BUSY);
  assign stall_req  = md_instr_d & (busy | w_start_mc);
  assign hi         = r_hi;
  assign lo         = r_lo;

  // Next-state and control. Any start seen while BUSY is dropped.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mc) begin
          w_state_next = ST_BUSY;
          w_cnt_next   = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          w_capture    = 1'b1;
        end else if (start && op == OP_MTHI) begin
          w_mt_hi = 1'b1;
        end else if (start && op == OP_MTLO) begin
          w_mt_lo = 1'b1;
        end
      end
      ST_BUSY: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = ST_IDLE;
          w_commit     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_ok <= 1'b0;
    end else begin
      if (w_capture) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_ok <= ~w_div_by_zero;
      end
      if (w_commit && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      if (w_mt_hi) r_hi <= a;
      if (w_mt_lo) r_lo <= a;
    end
  end

endmodule
`default_nettype wire
